w_data_memory: RTL and testbench

//  Data-memory responder at the far end of the register bank's W memory interface.

---
 rtl/w_data_memory.sv | 135 +++++++++++++
 tb/tb_w_data_memory.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/w_data_memory.sv
// Data-memory responder for the register bank's W interface: MR/MW requests, WAIT_CYCLES wait states, mem_ready pulse.
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word and flag read mismatches on mem_err.
module w_data_memory #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] W_IN,
    output logic [DATA_W-1:0] W_MEM_OUT,
    output logic              mem_ready,
    output logic              busy,
    output logic              mem_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_req_one;
    logic              w_req_both;
    logic              w_access;
    logic              w_acc_wr;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_data;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_rd_word;
    logic              w_par_err;
    logic              w_set_err;
    logic              w_busy_next;
    logic              w_ready_next;

    assign w_req_one  = MR ^ MW;
    assign w_req_both = MR & MW;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_one) w_state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            S_WAIT:  if (r_cnt == 4'd1) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output/access decode; with zero wait states the access happens straight from IDLE using live inputs.
    always_comb begin
        w_access     = (w_state_next == S_DONE);
        w_acc_wr     = (r_state == S_IDLE) ? MW   : r_is_wr;
        w_acc_addr   = (r_state == S_IDLE) ? ADDR : r_addr;
        w_acc_data   = (r_state == S_IDLE) ? W_IN : r_data;
        w_busy_next  = (w_state_next != S_IDLE);
        w_ready_next = (w_state_next == S_DONE);
        w_mem_we     = w_access & w_acc_wr & ~reset;
    end

`ifdef MEM_PARITY_EN
    assign w_wr_word = {^w_acc_data, w_acc_data};
    assign w_rd_word = r_mem[w_acc_addr];
    assign w_par_err = w_rd_word[DATA_W] != (^w_rd_word[DATA_W-1:0]);
`else
    assign w_wr_word = w_acc_data;
    assign w_rd_word = r_mem[w_acc_addr];
    assign w_par_err = 1'b0;
`endif

    assign w_set_err = ((r_state == S_IDLE) & w_req_both) | (w_access & ~w_acc_wr & w_par_err);

    // NOTE: the storage array has no reset; contents survive reset and a write is gated off while reset is high.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_acc_addr] <= w_wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req_one) begin
                r_cnt   <= 4'(WAIT_CYCLES);
                r_is_wr <= MW;
                r_addr  <= ADDR;
                r_data  <= W_IN;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !w_acc_wr) r_rdata <= w_rd_word[DATA_W-1:0];
            if (w_set_err) r_err <= 1'b1;
            r_ready <= w_ready_next;
            r_busy  <= w_busy_next;
        end
    end

    assign W_MEM_OUT = r_rdata;
    assign mem_ready = r_ready;
    assign busy      = r_busy;
    assign mem_err   = r_err;

endmodule

// File: tb/tb_w_data_memory.sv
// Self-checking bench for w_data_memory: directed scenarios plus randomized traffic against an array model.
module tb_w_data_memory;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MR, MW;
    logic [7:0]  ADDR;
    logic [15:0] W_IN;
    logic [15:0] W_MEM_OUT;
    logic        mem_ready, busy, mem_err;

    logic        mr0, mw0;
    logic [7:0]  addr0;
    logic [15:0] win0;
    logic [15:0] rdata0;
    logic        ready0, busy0, err0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m [256];
    bit          valid [256];
    logic [7:0]  written [$];
    logic [15:0] last_rd;
    logic        err_exp;

    always #5 clk = ~clk;

    w_data_memory #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset), .MR(MR), .MW(MW), .ADDR(ADDR), .W_IN(W_IN),
        .W_MEM_OUT(W_MEM_OUT), .mem_ready(mem_ready), .busy(busy), .mem_err(mem_err)
    );

    w_data_memory #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MR(mr0), .MW(mw0), .ADDR(addr0), .W_IN(win0),
        .W_MEM_OUT(rdata0), .mem_ready(ready0), .busy(busy0), .mem_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request on the main instance: mem_ready exactly WAIT+1 cycles after the request cycle.
    task automatic request(input bit is_wr, input logic [7:0] a, input logic [15:0] d);
        int lat, n_rdy, busy_bad;
        lat = 0; n_rdy = 0; busy_bad = 0;
        MR = !is_wr; MW = is_wr; ADDR = a; W_IN = d;
        for (int i = 1; i <= WAIT + 3; i++) begin
            tick();
            MR = 1'b0; MW = 1'b0; ADDR = 8'($urandom); W_IN = 16'($urandom);
            if (mem_ready === 1'b1) begin
                n_rdy++;
                if (lat == 0) lat = i;
            end
            if (busy !== 1'(i <= WAIT + 1)) busy_bad++;
        end
        check("latency", lat, WAIT + 1);
        check("ready_count", n_rdy, 1);
        check("busy_shape", busy_bad, 0);
        if (is_wr) begin
            m[a] = d;
            if (!valid[a]) written.push_back(a);
            valid[a] = 1'b1;
        end else begin
            last_rd = m[a];
        end
        check(is_wr ? "rdata_hold_after_write" : "rdata", W_MEM_OUT, last_rd);
        check("mem_err", mem_err, err_exp);
    endtask

    initial begin
        int n_rdy;
        reset = 1'b1; MR = 1'b0; MW = 1'b0; ADDR = '0; W_IN = '0;
        mr0 = 1'b0; mw0 = 1'b0; addr0 = '0; win0 = '0;
        last_rd = '0; err_exp = 1'b0;
        tick(); tick();
        check("rst_rdata", W_MEM_OUT, 16'h0);
        check("rst_ready", mem_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", mem_err, 1'b0);
        reset = 1'b0;
        tick();

        // Write then read back.
        request(1'b1, 8'h05, 16'hBEEF);
        request(1'b0, 8'h05, 16'h0000);

        // Zero-wait-state build: completion in cycle 1, busy for cycle 1 only.
        mw0 = 1'b1; addr0 = 8'h33; win0 = 16'h5A5A;
        tick();
        mw0 = 1'b0; addr0 = 8'h00; win0 = 16'h0000;
        check("w0_wr_ready", ready0, 1'b1);
        check("w0_wr_busy", busy0, 1'b1);
        tick();
        check("w0_wr_ready_low", ready0, 1'b0);
        check("w0_wr_busy_low", busy0, 1'b0);
        mr0 = 1'b1; addr0 = 8'h33;
        tick();
        mr0 = 1'b0; addr0 = 8'h00;
        check("w0_rd_ready", ready0, 1'b1);
        check("w0_rd_data", rdata0, 16'h5A5A);
        check("w0_rd_busy", busy0, 1'b1);
        tick();
        check("w0_rd_busy_low", busy0, 1'b0);
        check("w0_rd_hold", rdata0, 16'h5A5A);

        // Request while busy is dropped.
        request(1'b1, 8'h06, 16'h1357);
        MR = 1'b1; ADDR = 8'h05;
        tick();
        MR = 1'b1; ADDR = 8'h06;
        tick();
        MR = 1'b0; ADDR = 8'h00;
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_ready === 1'b1) n_rdy++;
            tick();
        end
        last_rd = m[8'h05];
        check("busy_drop_ready_count", n_rdy, 1);
        check("busy_drop_rdata", W_MEM_OUT, last_rd);

        // Collision: sticky error, no access.
        MR = 1'b1; MW = 1'b1; ADDR = 8'h05; W_IN = 16'h1111;
        tick();
        MR = 1'b0; MW = 1'b0;
        err_exp = 1'b1;
        check("collide_err", mem_err, 1'b1);
        check("collide_busy", busy, 1'b0);
        tick();
        check("collide_busy_later", busy, 1'b0);
        check("collide_ready", mem_ready, 1'b0);
        request(1'b0, 8'h05, 16'h0000);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            if (written.size() == 0 || $urandom_range(1, 0) == 1)
                request(1'b1, 8'($urandom_range(15, 0)), 16'($urandom));
            else
                request(1'b0, written[$urandom_range(written.size() - 1, 0)], 16'h0);
        end

        // Reset during WAIT discards the write.
        request(1'b1, 8'h10, 16'hAAAA);
        request(1'b0, 8'h06, 16'h0000);
        MW = 1'b1; ADDR = 8'h10; W_IN = 16'h1234;
        tick();
        MW = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("midrst_rdata", W_MEM_OUT, 16'h0);
        check("midrst_ready", mem_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err", mem_err, 1'b0);
        tick(); tick();
        reset = 1'b0;
        last_rd = '0; err_exp = 1'b0;
        tick();
        request(1'b0, 8'h10, 16'h0000);

        // Parity: corrupt one stored data bit and read it back.
        request(1'b1, 8'h20, 16'h00F0);
`ifdef MEM_PARITY_EN
        dut.r_mem[8'h20][3] = ~dut.r_mem[8'h20][3];
        m[8'h20] = 16'h00F8;
        err_exp = 1'b1;
`endif
        request(1'b0, 8'h20, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
